// File: rtl/fixed_multiply.sv
`timescale 1ns/1ps
// fixed_multiply: iterative shift-add multiply of a Q10.10 unsigned value by a small unsigned integer,
// giving the full Q13.10 product plus a rounded, saturated integer. Option macro: MUL_EARLY_TERM_EN.
module fixed_multiply #(
   parameter  int INT_W  = 10,
   parameter  int FRAC_W = 10,
   parameter  int MPLR_W = 3,
   localparam int P_W    = INT_W + FRAC_W + MPLR_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   input  logic [INT_W+FRAC_W-1:0] in_data_1,
   input  logic [MPLR_W-1:0]       in_data_2,
   output logic                    out_valid,
   output logic [P_W-1:0]          out_data,
   output logic [INT_W-1:0]        out_int,
   output logic                    out_sat
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      MULT = 2'd2,
      DONE = 2'd3
   } state_t;

   // Rounding is done one bit wider than the product so the half-LSB add cannot wrap.
   localparam int R_W = P_W + 1;
   localparam logic [R_W-1:0] HALF_C    = {{(R_W-1){1'b0}}, 1'b1} << (FRAC_W - 1);
   localparam logic [R_W-1:0] INT_MAX_C = {{(R_W-INT_W){1'b0}}, {INT_W{1'b1}}};

   state_t              state_r;
   logic [P_W-1:0]      mcand_r;
   logic [MPLR_W-1:0]   mplr_r;
   logic [P_W-1:0]      acc_r;
   logic                out_valid_r;
   logic [P_W-1:0]      out_data_r;
   logic [INT_W-1:0]    out_int_r;
   logic                out_sat_r;

   logic [R_W-1:0]      round_sum_s;
   logic [R_W-1:0]      round_s;
   logic [INT_W-1:0]    int_res_s;
   logic                sat_s;
   logic                mult_last_s;

`ifndef MUL_EARLY_TERM_EN
   localparam logic [1:0] LAST_ITER_C = 2'(MPLR_W - 1);
   logic [1:0]          iter_cnt_r;
`endif

   // Round the accumulator half-up to an integer and clamp it to the integer range.
   always_comb begin
      round_sum_s = {1'b0, acc_r} + HALF_C;
      round_s     = round_sum_s >> FRAC_W;
      if (round_s > INT_MAX_C) begin
         sat_s     = 1'b1;
         int_res_s = {INT_W{1'b1}};
      end else begin
         sat_s     = 1'b0;
         int_res_s = round_s[INT_W-1:0];
      end
   end

   // Decide whether the current MULT cycle is the last one.
   always_comb begin
`ifdef MUL_EARLY_TERM_EN
      mult_last_s = ((mplr_r >> 1) == {MPLR_W{1'b0}});
`else
      mult_last_s = (iter_cnt_r == LAST_ITER_C);
`endif
   end

   // Control FSM, shift-add datapath and registered result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         mcand_r     <= {P_W{1'b0}};
         mplr_r      <= {MPLR_W{1'b0}};
         acc_r       <= {P_W{1'b0}};
         out_valid_r <= 1'b0;
         out_data_r  <= {P_W{1'b0}};
         out_int_r   <= {INT_W{1'b0}};
         out_sat_r   <= 1'b0;
`ifndef MUL_EARLY_TERM_EN
         iter_cnt_r  <= 2'd0;
`endif
      end else begin
         out_valid_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  mcand_r <= {{MPLR_W{1'b0}}, in_data_1};
                  mplr_r  <= in_data_2;
                  state_r <= LOAD;
               end else begin
                  state_r <= IDLE;
               end
            end
            LOAD: begin
               // Keep resampling while in_valid is held; the last pair seen wins.
               if (in_valid) begin
                  mcand_r <= {{MPLR_W{1'b0}}, in_data_1};
                  mplr_r  <= in_data_2;
                  state_r <= LOAD;
               end else begin
                  acc_r   <= {P_W{1'b0}};
`ifndef MUL_EARLY_TERM_EN
                  iter_cnt_r <= 2'd0;
`endif
                  state_r <= MULT;
               end
            end
            MULT: begin
               if (mplr_r[0]) begin
                  acc_r <= acc_r + mcand_r;
               end else begin
                  acc_r <= acc_r;
               end
               mcand_r <= mcand_r << 1;
               mplr_r  <= mplr_r >> 1;
`ifndef MUL_EARLY_TERM_EN
               iter_cnt_r <= iter_cnt_r + 2'd1;
`endif
               if (mult_last_s) begin
                  state_r <= DONE;
               end else begin
                  state_r <= MULT;
               end
            end
            DONE: begin
               out_valid_r <= 1'b1;
               out_data_r  <= acc_r;
               out_int_r   <= int_res_s;
               out_sat_r   <= sat_s;
               state_r     <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_int   = out_int_r;
   assign out_sat   = out_sat_r;

endmodule

// File: tb/tb_fixed_multiply.sv
`timescale 1ns/1ps
// Self-checking bench for fixed_multiply: arithmetic reference model with per-cycle compare
// plus directed vectors with hand-computed literal results and latencies.
module tb_fixed_multiply;

   typedef struct packed {
      logic [22:0] prod;
      logic [9:0]  oi;
      logic        os;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [19:0] in_data_1;
   logic [2:0]  in_data_2;
   logic        out_valid;
   logic [22:0] out_data;
   logic [9:0]  out_int;
   logic        out_sat;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   res_t exp_at[int];
   res_t held = '0;

`ifdef MUL_EARLY_TERM_EN
   localparam int LAT_33 = 3;
   localparam int LAT_Z  = 2;
`else
   localparam int LAT_33 = 4;
   localparam int LAT_Z  = 4;
`endif

   fixed_multiply dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .in_data_1(in_data_1), .in_data_2(in_data_2),
      .out_valid(out_valid), .out_data(out_data),
      .out_int(out_int), .out_sat(out_sat)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic res_t model(input logic [19:0] a, input logic [2:0] b);
      res_t   r;
      longint p;
      longint rnd;
      p      = longint'(a) * longint'(b);
      rnd    = (p + 512) / 1024;
      r.prod = p[22:0];
      r.os   = (rnd > 1023);
      r.oi   = r.os ? 10'd1023 : rnd[9:0];
      return r;
   endfunction

   function automatic int lat_k(input logic [2:0] b);
      int k;
      k = 1;
      for (int i = 0; i < 3; i++) if (b[i]) k = i + 1;
`ifndef MUL_EARLY_TERM_EN
      k = 3;
`endif
      return k;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic start_op(input logic [19:0] a, input logic [2:0] b);
      in_valid  = 1'b1;
      in_data_1 = a;
      in_data_2 = b;
      @(negedge clk);
   endtask

   task automatic end_op(input logic [19:0] a, input logic [2:0] b, output int e_l);
      in_valid = 1'b0;
      e_l = cyc + 1;
      exp_at[e_l + lat_k(b) + 1] = model(a, b);
   endtask

   task automatic wait_out(output int when_c, output res_t got);
      when_c = -1;
      got    = '0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            when_c = cyc;
            got    = {out_data, out_int, out_sat};
            break;
         end
      end
      if (when_c < 0) begin
         checks++;
         errors++;
         $display("FAIL timeout act=no_out_valid exp=out_valid_within_16");
      end
   endtask

   // Per-cycle compare against the reference model.
   initial begin
      logic exp_v;
      forever begin
         @(negedge clk);
         if (exp_at.exists(cyc)) begin
            held  = exp_at[cyc];
            exp_at.delete(cyc);
            exp_v = 1'b1;
         end else begin
            exp_v = 1'b0;
         end
         checks++;
         if (out_valid !== exp_v) begin
            errors++;
            $display("FAIL strobe cyc=%0d act=%b exp=%b", cyc, out_valid, exp_v);
         end
         checks++;
         if ({out_data, out_int, out_sat} !== held) begin
            errors++;
            $display("FAIL result cyc=%0d act=%h/%0d/%b exp=%h/%0d/%b", cyc,
                     out_data, out_int, out_sat, held.prod, held.oi, held.os);
         end
      end
   end

   initial begin
      int   e_l;
      int   when_c;
      int   key;
      res_t got;
      rst_n = 1'b0; in_valid = 1'b0; in_data_1 = 20'h0; in_data_2 = 3'd0;
      @(negedge clk); @(negedge clk);
      chk("reset_valid", longint'(out_valid), 0);
      chk("reset_data", longint'(out_data), 0);
      chk("reset_int", longint'(out_int), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // 3.0 x 3, single-cycle pulse
      start_op(20'h00C00, 3'd3); end_op(20'h00C00, 3'd3, e_l);
      wait_out(when_c, got);
      chk("x3_data", longint'(got.prod), 23'h002400);
      chk("x3_int", longint'(got.oi), 9);
      chk("x3_sat", longint'(got.os), 0);
      chk("x3_lat", longint'(when_c - e_l), LAT_33);

      // divider round-trip, rounds up
      start_op(20'h00155, 3'd3); end_op(20'h00155, 3'd3, e_l);
      wait_out(when_c, got);
      chk("rt_data", longint'(got.prod), 23'h0003FF);
      chk("rt_int", longint'(got.oi), 1);

      // saturation
      start_op(20'hFFFFF, 3'd7); end_op(20'hFFFFF, 3'd7, e_l);
      wait_out(when_c, got);
      chk("sat_data", longint'(got.prod), 23'h6FFFF9);
      chk("sat_int", longint'(got.oi), 1023);
      chk("sat_flag", longint'(got.os), 1);
      chk("sat_lat", longint'(when_c - e_l), 4);

      // zero multiplier
      start_op(20'h12345, 3'd0); end_op(20'h12345, 3'd0, e_l);
      wait_out(when_c, got);
      chk("zero_data", longint'(got.prod), 0);
      chk("zero_int", longint'(got.oi), 0);
      chk("zero_sat", longint'(got.os), 0);
      chk("zero_lat", longint'(when_c - e_l), LAT_Z);

      // multi-cycle in_valid, last pair wins; pulse during MULT is ignored
      start_op(20'h00400, 3'd1);
      start_op(20'h00800, 3'd2);
      start_op(20'h01000, 3'd5);
      end_op(20'h01000, 3'd5, e_l);
      @(negedge clk);
      in_valid = 1'b1; in_data_1 = 20'hFFFFF; in_data_2 = 3'd7;
      @(negedge clk);
      in_valid = 1'b0;
      wait_out(when_c, got);
      chk("last_data", longint'(got.prod), 23'h005000);
      chk("last_int", longint'(got.oi), 20);
      chk("last_lat", longint'(when_c - e_l), 4);

      // back-to-back: new operand in the out_valid cycle
      start_op(20'h00155, 3'd3); end_op(20'h00155, 3'd3, e_l);
      wait_out(when_c, got);
      chk("b2b_data", longint'(got.prod), 23'h0003FF);
      chk("b2b_lat", longint'(when_c - e_l), LAT_33);

      // asynchronous reset in the middle of MULT
      start_op(20'h00C00, 3'd3); end_op(20'h00C00, 3'd3, e_l);
      key = e_l + lat_k(3'd3) + 1;
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      exp_at.delete(key);
      held = '0;
      #1;
      chk("rst_mid_valid", longint'(out_valid), 0);
      chk("rst_mid_data", longint'(out_data), 0);
      chk("rst_mid_int", longint'(out_int), 0);
      chk("rst_mid_sat", longint'(out_sat), 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_op(20'h00C00, 3'd3); end_op(20'h00C00, 3'd3, e_l);
      wait_out(when_c, got);
      chk("post_rst_data", longint'(got.prod), 23'h002400);
      chk("post_rst_lat", longint'(when_c - e_l), LAT_33);

      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
